// File: rtl/mlaccel_pkg.sv
// Shared definitions for the ML accelerator MAC sequencer: opcodes,
// instruction word layout and sequencer state encoding.
package mlaccel_pkg;

  localparam logic [5:0] OP_MACC_CLR = 6'b100011;
  localparam logic [5:0] OP_MACC     = 6'b100010;
  localparam logic [5:0] OP_STORE    = 6'b010000;
  localparam logic [5:0] OP_NOP      = 6'b000000;

  // Opcode word field positions and widths.
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned ARG_LSB  = 6;
  localparam int unsigned ARG_W    = 8;
  localparam int unsigned ADDR_LSB = 14;
  localparam int unsigned ADDR_W   = 18;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ARG_W-1:0]  arg;
    logic [OP_W-1:0]   op;
  } inst_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic is_mac(input logic [OP_W-1:0] op);
    return (op == OP_MACC) || (op == OP_MACC_CLR);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_MACC) || (op == OP_MACC_CLR) || (op == OP_STORE) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/mlaccel_macseq_dot.sv
// Registered LANES-wide signed-coefficient x unsigned-byte dot product.
// Products are registered; the sum over lanes is combinational from them.
module mlaccel_macseq_dot #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8*LANES-1:0] coeff,
  input  logic [8*LANES-1:0] data,
  output logic [ACC_W-1:0]   dot
);

  logic signed [16:0] prod [LANES];

  // Register one signed 8x9 product per lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) prod[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        prod[i] <= $signed(coeff[8*i +: 8]) * $signed({1'b0, data[8*i +: 8]});
      end
    end
  end

  // Sign-extend each product and sum with wrap-around.
  always_comb begin
    dot = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dot = dot + {{(ACC_W-17){prod[i][16]}}, prod[i]};
    end
  end

endmodule

// File: rtl/mlaccel_macseq.sv
// MAC sequencer: code RAM of coefficient/opcode pairs executed through an
// F/M/D/A pipeline against the shared data memory.
// Build option: MLACCEL_MACSEQ_RELU_EN selects unsigned 0..255 store
// saturation; otherwise stores saturate to signed -128..127.
module mlaccel_macseq
  import mlaccel_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned CODE_AW = 11,
  parameter int unsigned MEM_AW  = 17,
  parameter int unsigned ACC_W   = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CODE_AW-1:0] ctrl_addr,
  input  logic [CODE_AW-1:0] ctrl_execute,
  input  logic               ctrl_abort,
  output logic               ctrl_busy,
  output logic               ctrl_done,
  output logic               ctrl_error,
  input  logic [LANES-1:0]   ctrl_wen_coeff,
  input  logic               ctrl_wen_opcode,
  input  logic [8*LANES-1:0] ctrl_wdata_coeff,
  input  logic [31:0]        ctrl_wdata_opcode,
  output logic               mem_wen,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [8*LANES-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 1 << CODE_AW;

  logic [8*LANES-1:0] coeff_mem  [DEPTH];
  logic [31:0]        opcode_mem [DEPTH];

  state_t state, state_n;

  logic [CODE_AW-1:0] pc, fetch_left;
  logic               m_valid;
  inst_t              m_inst;
  logic [8*LANES-1:0] m_coeff, d_coeff;
  logic               d_valid, d_mac, d_clr;
  logic               a_mac, a_clr;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]   dot;
  logic               error;

  logic start, stall, f_active, more, m_store;
  logic [CODE_AW-1:0] fetch_left_n;
  logic               m_valid_n, d_valid_n;

  // Code RAM writes, only accepted while idle; contents survive reset.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (ctrl_wen_coeff[i]) coeff_mem[ctrl_addr][8*i +: 8] <= ctrl_wdata_coeff[8*i +: 8];
      end
      if (ctrl_wen_opcode) opcode_mem[ctrl_addr] <= ctrl_wdata_opcode;
    end
  end

  // Hazard detection and lookahead of pipeline occupancy after this cycle.
  always_comb begin
    m_store      = m_valid && (m_inst.op == OP_STORE);
    stall        = m_store && (d_mac || a_mac);
    f_active     = (fetch_left != '0);
    fetch_left_n = fetch_left;
    if (f_active && !stall) fetch_left_n = fetch_left - CODE_AW'(1);
    m_valid_n    = stall ? 1'b1 : f_active;
    d_valid_n    = m_valid && !stall;
    // An instruction in D now will be in A next cycle and keeps busy high.
    more         = (fetch_left_n != '0) || m_valid_n || d_valid_n || d_valid;
    start        = (state == ST_IDLE) && (ctrl_execute != '0) && !ctrl_abort;
  end

  // Sequencer next-state: idle until a start, run until drained or aborted.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_RUN;
      ST_RUN:  if (ctrl_abort || !more) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and one-cycle done pulse on the run->idle transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_done <= 1'b0;
    end else begin
      state     <= state_n;
      ctrl_done <= (state == ST_RUN) && (state_n == ST_IDLE);
    end
  end

  // Pipeline registers, accumulator and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= '0;
      fetch_left <= '0;
      m_valid    <= 1'b0;
      m_inst     <= '0;
      m_coeff    <= '0;
      d_valid    <= 1'b0;
      d_mac      <= 1'b0;
      d_clr      <= 1'b0;
      d_coeff    <= '0;
      a_mac      <= 1'b0;
      a_clr      <= 1'b0;
      acc        <= '0;
      error      <= 1'b0;
    end else if (start) begin
      pc         <= ctrl_addr;
      fetch_left <= ctrl_execute;
      error      <= 1'b0;
    end else if (state == ST_RUN) begin
      if (ctrl_abort) begin
        fetch_left <= '0;
        m_valid    <= 1'b0;
        d_valid    <= 1'b0;
        d_mac      <= 1'b0;
        a_mac      <= 1'b0;
      end else begin
        // A stalled STORE keeps M and F frozen; D receives a bubble.
        if (!stall) begin
          m_valid <= f_active;
          if (f_active) begin
            m_inst     <= opcode_mem[pc];
            m_coeff    <= coeff_mem[pc];
            pc         <= pc + CODE_AW'(1);
            fetch_left <= fetch_left - CODE_AW'(1);
          end
          if (m_valid && !is_legal(m_inst.op)) error <= 1'b1;
        end
        d_valid <= d_valid_n;
        d_mac   <= d_valid_n && is_mac(m_inst.op);
        d_clr   <= m_inst.op == OP_MACC_CLR;
        d_coeff <= m_coeff;
        a_mac   <= d_mac;
        a_clr   <= d_clr;
        if (a_mac) acc <= a_clr ? $signed(dot) : acc + $signed(dot);
      end
    end
  end

  mlaccel_macseq_dot #(
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_dot (
    .clock (clock),
    .reset (reset),
    .coeff (d_coeff),
    .data  (mem_rdata),
    .dot   (dot)
  );

  logic [4:0]              sh_raw, sh;
  logic signed [ACC_W-1:0] shifted;

`ifdef MLACCEL_MACSEQ_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] SAT_LO = '0;
`else
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);
`endif

  // Arithmetic shift with clamped amount, then saturate to a store byte.
  always_comb begin
    sh_raw  = 5'(m_inst.arg);
    sh      = (sh_raw >= 5'(ACC_W)) ? 5'(ACC_W - 1) : sh_raw;
    shifted = acc >>> sh;
    if (shifted > SAT_HI)      mem_wdata = SAT_HI[7:0];
    else if (shifted < SAT_LO) mem_wdata = SAT_LO[7:0];
    else                       mem_wdata = shifted[7:0];
  end

  assign mem_addr   = MEM_AW'(m_inst.addr);
  assign mem_wen    = (state == ST_RUN) && m_store && !stall && !ctrl_abort;
  assign ctrl_busy  = (state == ST_RUN);
  assign ctrl_error = error;

endmodule

// File: tb/tb_mlaccel_macseq.sv
// Directed testbench for mlaccel_macseq with a behavioural data memory.
module tb_mlaccel_macseq;

  localparam logic [5:0] OP_MACC_CLR = 6'b100011;
  localparam logic [5:0] OP_MACC     = 6'b100010;
  localparam logic [5:0] OP_STORE    = 6'b010000;
  localparam logic [5:0] OP_NOP      = 6'b000000;

`ifdef MLACCEL_MACSEQ_RELU_EN
  localparam logic [7:0] EXP_ARG0 = 8'hFF;
  localparam logic [7:0] EXP_ARG2 = 8'hD0;
  localparam logic [7:0] EXP_NEG  = 8'h00;
`else
  localparam logic [7:0] EXP_ARG0 = 8'h7F;
  localparam logic [7:0] EXP_ARG2 = 8'h7F;
  localparam logic [7:0] EXP_NEG  = 8'hF1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] ctrl_addr, ctrl_execute;
  logic        ctrl_abort, ctrl_busy, ctrl_done, ctrl_error;
  logic [3:0]  ctrl_wen_coeff;
  logic        ctrl_wen_opcode;
  logic [31:0] ctrl_wdata_coeff, ctrl_wdata_opcode;
  logic        mem_wen;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  mlaccel_macseq dut (
    .clock             (clock),
    .reset             (reset),
    .ctrl_addr         (ctrl_addr),
    .ctrl_execute      (ctrl_execute),
    .ctrl_abort        (ctrl_abort),
    .ctrl_busy         (ctrl_busy),
    .ctrl_done         (ctrl_done),
    .ctrl_error        (ctrl_error),
    .ctrl_wen_coeff    (ctrl_wen_coeff),
    .ctrl_wen_opcode   (ctrl_wen_opcode),
    .ctrl_wdata_coeff  (ctrl_wdata_coeff),
    .ctrl_wdata_opcode (ctrl_wdata_opcode),
    .mem_wen           (mem_wen),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata)
  );

  logic [7:0] mem [0:(1<<17)-1];

  // Data memory: read data one cycle after the address, byte writes.
  always @(posedge clock) begin : mem_model
    logic [16:0] a;
    for (int i = 0; i < 4; i++) begin
      a = mem_addr + 17'(i);
      mem_rdata[8*i +: 8] <= mem[a];
    end
    if (mem_wen) mem[mem_addr] <= mem_wdata;
  end

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned busy_cnt, done_cnt, wen_cnt;
  logic [16:0] wen_addr;
  logic [7:0]  wen_data;

  // Output monitor sampled mid-cycle.
  always @(negedge clock) begin
    if (ctrl_busy === 1'b1) busy_cnt++;
    if (ctrl_done === 1'b1) done_cnt++;
    if (mem_wen === 1'b1) begin
      wen_cnt++;
      wen_addr = mem_addr;
      wen_data = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] opw(input logic [5:0] op, input logic [7:0] arg,
                                      input logic [17:0] addr);
    return {addr, arg, op};
  endfunction

  task automatic write_code(input logic [10:0] a, input logic [31:0] coeff, input logic [31:0] opc);
    @(posedge clock); #1;
    ctrl_addr         = a;
    ctrl_wdata_coeff  = coeff;
    ctrl_wdata_opcode = opc;
    ctrl_wen_coeff    = 4'hF;
    ctrl_wen_opcode   = 1'b1;
    @(posedge clock); #1;
    ctrl_wen_coeff    = 4'h0;
    ctrl_wen_opcode   = 1'b0;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
    wen_cnt  = 0;
  endtask

  task automatic run_prog(input string tag, input logic [10:0] a, input logic [10:0] n);
    logic fin;
    @(posedge clock); #1;
    clear_counts();
    ctrl_addr    = a;
    ctrl_execute = n;
    @(posedge clock); #1;
    ctrl_execute = '0;
    fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done_cnt != 0) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) check({tag, " timeout"}, 32'(fin), 32'd1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ctrl_addr = '0; ctrl_execute = '0; ctrl_abort = 1'b0;
    ctrl_wen_coeff = '0; ctrl_wen_opcode = 1'b0;
    ctrl_wdata_coeff = '0; ctrl_wdata_opcode = '0;
    clear_counts();
    for (int i = 0; i < (1 << 17); i++) mem[i] = 8'h55;
    for (int i = 0; i < 8; i++) mem[i] = 8'(1 << i);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset busy",  32'(ctrl_busy),  32'd0);
    check("reset done",  32'(ctrl_done),  32'd0);
    check("reset error", 32'(ctrl_error), 32'd0);
    check("reset wen",   32'(mem_wen),    32'd0);
    check("reset addr",  32'(mem_addr),   32'd0);
    check("reset wdata", 32'(mem_wdata),  32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    write_code(11'd0, 32'h04030201, opw(OP_MACC_CLR, 8'd0, 18'd0));
    write_code(11'd1, 32'h04030201, opw(OP_MACC,     8'd0, 18'd4));
    write_code(11'd2, 32'h0,        opw(OP_STORE,    8'd0, 18'h100));
    write_code(11'd3, 32'hFFFFFFFF, opw(OP_MACC_CLR, 8'd0, 18'd0));
    write_code(11'd4, 32'h0,        opw(OP_NOP,      8'd0, 18'd0));
    write_code(11'd5, 32'h0,        opw(OP_NOP,      8'd0, 18'd0));
    write_code(11'd6, 32'h0,        opw(OP_STORE,    8'd0, 18'h101));
    for (int i = 16; i < 34; i++) write_code(11'(i), 32'h0, opw(OP_MACC, 8'd0, 18'd0));
    for (int i = 40; i < 50; i++) write_code(11'(i), 32'h01010101, opw(OP_MACC, 8'd0, 18'd0));
    write_code(11'd50, 32'h0, opw(OP_STORE, 8'd0, 18'h102));
    write_code(11'd60, 32'h04030201, opw(OP_MACC_CLR, 8'd0, 18'd0));
    write_code(11'd61, 32'h01010101, opw(6'h3F,       8'd0, 18'd4));
    write_code(11'd62, 32'h0,        opw(OP_STORE,    8'd0, 18'h103));
    write_code(11'h7FF, 32'h01010101, opw(OP_MACC_CLR, 8'd0, 18'd4));

    // acc = 49 + 784 = 833; STORE right after MACC stalls 2 cycles.
    run_prog("basic", 11'd0, 11'd3);
    check("basic busy cycles", busy_cnt, 32'd8);
    check("basic done pulses", done_cnt, 32'd1);
    check("basic wen count",   wen_cnt,  32'd1);
    check("basic wen addr",    32'(wen_addr), 32'h100);
    check("basic mem[0x100]",  32'(mem[17'h100]), 32'(EXP_ARG0));
    check("basic error",       32'(ctrl_error), 32'd0);

    write_code(11'd2, 32'h0, opw(OP_STORE, 8'd2, 18'h100));
    run_prog("shift2", 11'd0, 11'd3);
    check("shift2 mem[0x100]", 32'(mem[17'h100]), 32'(EXP_ARG2));

    write_code(11'd2, 32'h0, opw(OP_STORE, 8'd3, 18'h100));
    run_prog("shift3", 11'd0, 11'd3);
    check("shift3 mem[0x100]", 32'(mem[17'h100]), 32'h68);
    check("shift3 wen data",   32'(wen_data),     32'h68);

    // acc = -15; STORE three slots later, no stall.
    run_prog("neg", 11'd3, 11'd4);
    check("neg busy cycles",  busy_cnt, 32'd7);
    check("neg mem[0x101]",   32'(mem[17'h101]), 32'(EXP_NEG));

    run_prog("macc18", 11'd16, 11'd18);
    check("macc18 busy cycles", busy_cnt, 32'd21);
    check("macc18 done pulses", done_cnt, 32'd1);
    check("macc18 wen count",   wen_cnt,  32'd0);

    // Abort before the STORE at 50 is fetched.
    @(posedge clock); #1;
    clear_counts();
    ctrl_addr = 11'd40; ctrl_execute = 11'd11;
    @(posedge clock); #1;
    ctrl_execute = '0;
    repeat (3) @(posedge clock);
    #1 ctrl_abort = 1'b1;
    @(posedge clock); #1;
    ctrl_abort = 1'b0;
    @(negedge clock);
    check("abort busy next", 32'(ctrl_busy), 32'd0);
    check("abort done next", 32'(ctrl_done), 32'd1);
    repeat (15) @(posedge clock);
    #1;
    check("abort wen count",  wen_cnt,  32'd0);
    check("abort done count", done_cnt, 32'd1);
    check("abort mem[0x102]", 32'(mem[17'h102]), 32'h55);

    // Start and abort together while idle: nothing runs.
    clear_counts();
    ctrl_addr = 11'd0; ctrl_execute = 11'd2; ctrl_abort = 1'b1;
    @(posedge clock); #1;
    ctrl_execute = '0; ctrl_abort = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("startabort busy", busy_cnt, 32'd0);
    check("startabort done", done_cnt, 32'd0);

    // Reset mid-run kills the run without a done pulse.
    clear_counts();
    ctrl_addr = 11'd16; ctrl_execute = 11'd18;
    @(posedge clock); #1;
    ctrl_execute = '0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("midreset done count", done_cnt, 32'd0);
    check("midreset busy",       32'(ctrl_busy), 32'd0);

    // Illegal op between MACC_CLR and STORE: acc stays 49, one stall cycle.
    run_prog("illegal", 11'd60, 11'd3);
    check("illegal error",      32'(ctrl_error), 32'd1);
    check("illegal busy",       busy_cnt, 32'd7);
    check("illegal mem[0x103]", 32'(mem[17'h103]), 32'h31);

    // PC wraps 0x7FF -> 0x000; acc = 240, stored >>> 1 = 0x78.
    write_code(11'd0, 32'h0, opw(OP_STORE, 8'd1, 18'h104));
    run_prog("wrap", 11'h7FF, 11'd2);
    check("wrap error cleared", 32'(ctrl_error), 32'd0);
    check("wrap busy",          busy_cnt, 32'd7);
    check("wrap wen count",     wen_cnt,  32'd1);
    check("wrap mem[0x104]",    32'(mem[17'h104]), 32'h78);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
